// File: rtl/lut_mux_seq.sv
// lut_mux_seq -- registered, reprogrammable logic function built from a
// mux with a residual variable, plus a sweep mode that walks every input
// code and captures the resulting truth table.
//
// The upper select bits pick one of NL = 2^(SEL_W-1) leaves. Each leaf
// holds a 2-bit code: 00 -> 0, 01 -> 1, 10 -> x[0], 11 -> ~x[0].
//
// Ports:
//   clk          single clock, rising edge
//   rst_n        synchronous active-low reset
//   x            direct-mode input variables (x[SEL_W-1:1] = leaf select)
//   cfg_we       leaf-code write enable (honoured in IDLE only)
//   cfg_addr     leaf index to write
//   cfg_code     leaf code to write
//   start        sweep request, level-sampled
//   y            registered function output
//   sweep_x      input code that produced y during a sweep
//   sweep_valid  y / sweep_x carry a sweep sample
//   busy         sweep in progress
//   done         one-cycle pulse at sweep completion
//   tt           captured truth table, tt[k] = f(k)
module lut_mux_seq #(
    parameter int SEL_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SEL_W-1:0]       x,
    input  logic                   cfg_we,
    input  logic [SEL_W-2:0]       cfg_addr,
    input  logic [1:0]             cfg_code,
    input  logic                   start,
    output logic                   y,
    output logic [SEL_W-1:0]       sweep_x,
    output logic                   sweep_valid,
    output logic                   busy,
    output logic                   done,
    output logic [(2**SEL_W)-1:0]  tt
);

    localparam int NL = 2 ** (SEL_W - 1);
    localparam int N  = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] CNT_LAST = SEL_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [1:0]       code [NL];
    logic [SEL_W-1:0] cnt;
    logic             f_x;
    logic             f_cnt;

    // Resolve one leaf code against the residual variable.
    function automatic logic leaf_decode(input logic [1:0] c, input logic v0);
        logic r;
        case (c)
            2'b00:   r = 1'b0;
            2'b01:   r = 1'b1;
            2'b10:   r = v0;
            default: r = ~v0;
        endcase
        return r;
    endfunction

    // Two evaluation ports into the same leaf table: one for the external
    // inputs, one for the sweep counter.
    assign f_x   = leaf_decode(code[x[SEL_W-1:1]], x[0]);
    assign f_cnt = leaf_decode(code[cnt[SEL_W-1:1]], cnt[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // DONE re-arms straight into SWEEP when start is still high, so that
    // back-to-back sweeps leave only a one-cycle hole in sweep_valid.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SWEEP;
            SWEEP:   if (cnt == CNT_LAST) state_nx = DONE;
            DONE:    state_nx = start ? SWEEP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NL; i++) begin
                code[i] <= 2'b00;
            end
            cnt         <= '0;
            y           <= 1'b0;
            sweep_x     <= '0;
            sweep_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tt          <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // A write coinciding with start lands now, before the
                    // first sweep evaluation on the following edge.
                    if (cfg_we) begin
                        code[cfg_addr] <= cfg_code;
                    end
                    y <= f_x;
                    if (start) begin
                        cnt  <= '0;
                        busy <= 1'b1;
                    end
                end
                SWEEP: begin
                    y           <= f_cnt;
                    sweep_x     <= cnt;
                    sweep_valid <= 1'b1;
                    tt[cnt]     <= f_cnt;
                    cnt         <= cnt + 1'b1;
                end
                DONE: begin
                    sweep_valid <= 1'b0;
                    done        <= 1'b1;
                    y           <= f_x;
                    busy        <= start;
                    cnt         <= '0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_mux_seq.sv
// Self-checking bench for lut_mux_seq (SEL_W = 3).
module tb_lut_mux_seq;

    localparam int SEL_W = 3;
    localparam int NL    = 4;
    localparam int N     = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [SEL_W-1:0] x;
    logic             cfg_we;
    logic [SEL_W-2:0] cfg_addr;
    logic [1:0]       cfg_code;
    logic             start;
    logic             y;
    logic [SEL_W-1:0] sweep_x;
    logic             sweep_valid;
    logic             busy;
    logic             done;
    logic [N-1:0]     tt;

    int total = 0;
    int bad   = 0;

    // Reference leaf table, as the bench believes it is programmed.
    int mc [NL];

    always #5 clk = ~clk;

    lut_mux_seq #(.SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_code(cfg_code), .start(start), .y(y), .sweep_x(sweep_x),
        .sweep_valid(sweep_valid), .busy(busy), .done(done), .tt(tt)
    );

    // f(v): leaf v/2, residual bit v%2.
    function automatic logic fm(input int v);
        int c;
        int r;
        c = mc[v / 2];
        r = v % 2;
        if (c == 0) return 1'b0;
        if (c == 1) return 1'b1;
        if (c == 2) return (r == 1);
        return (r == 0);
    endfunction

    function automatic logic [N-1:0] ttm();
        logic [N-1:0] t;
        for (int k = 0; k < N; k++) t[k] = fm(k);
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int c);
        cfg_we   = 1'b1;
        cfg_addr = (SEL_W-1)'(a);
        cfg_code = 2'(c);
        mc[a]    = c;
        tick();
        cfg_we   = 1'b0;
    endtask

    // One full sweep from IDLE. With disturb set, a leaf-3 write and a
    // start pulse are injected mid-sweep; both must be ignored.
    task automatic do_sweep(input bit disturb);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("sw_busy_e0", 32'(busy), 32'd1);
        chk("sw_valid_e0", 32'(sweep_valid), 32'd0);
        for (int k = 0; k < N; k++) begin
            if (disturb && k == 2) begin
                cfg_we = 1'b1; cfg_addr = 2'd3; cfg_code = 2'b01; start = 1'b1;
            end
            tick();
            cfg_we = 1'b0;
            start  = 1'b0;
            chk("sw_valid", 32'(sweep_valid), 32'd1);
            chk("sw_x", 32'(sweep_x), 32'(k));
            chk("sw_y", 32'(y), 32'(fm(k)));
            chk("sw_done_low", 32'(done), 32'd0);
        end
        tick();
        chk("sw_done", 32'(done), 32'd1);
        chk("sw_busy_end", 32'(busy), 32'd0);
        chk("sw_valid_end", 32'(sweep_valid), 32'd0);
        chk("sw_tt", 32'(tt), 32'(ttm()));
        tick();
        chk("sw_done_clear", 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int dq[$];
        logic [N-1:0] tt_first;

        rst_n = 1'b0; x = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_code = '0; start = 1'b0;
        for (int i = 0; i < NL; i++) mc[i] = 0;
        tick();
        tick();
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_sweep_x", 32'(sweep_x), 32'd0);
        chk("rst_valid", 32'(sweep_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tt", 32'(tt), 32'd0);
        rst_n = 1'b1;

        // Direct mode after reset: f is identically 0.
        for (int v = 0; v < N; v++) begin
            x = SEL_W'(v);
            tick();
            chk("direct_zero", 32'(y), 32'd0);
        end

        // Program {0:01, 1:10, 2:11, 3:00} -> 1,1,0,1,1,0,0,0.
        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 0);
        for (int v = 0; v < N; v++) begin
            x = SEL_W'(v);
            tick();
            chk("direct_y", 32'(y), 32'(fm(v)));
        end

        do_sweep(1'b0);
        chk("tt_1b", 32'(tt), 32'h1B);

        // Mid-sweep write and start are ignored; then a real write.
        do_sweep(1'b1);
        chk("tt_still_1b", 32'(tt), 32'h1B);
        tick();
        chk("single_done", 32'(done), 32'd0);
        wr(3, 1);
        do_sweep(1'b0);
        chk("tt_db", 32'(tt), 32'hDB);

        // Reset at sweep sample 4.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 4; k++) tick();
        chk("pre_rst_x", 32'(sweep_x), 32'd4);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NL; i++) mc[i] = 0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_tt", 32'(tt), 32'd0);
        chk("mid_rst_valid", 32'(sweep_valid), 32'd0);
        for (int k = 0; k < N + 2; k++) begin
            tick();
            chk("mid_rst_no_done", 32'(done), 32'd0);
        end
        do_sweep(1'b0);
        chk("tt_after_rst", 32'(tt), 32'd0);

        // Random leaf codes and random direct-mode inputs.
        for (int r = 0; r < 3; r++) begin
            for (int a = 0; a < NL; a++) wr(a, int'($urandom_range(3, 0)));
            for (int i = 0; i < 12; i++) begin
                int v;
                v = int'($urandom_range(N - 1, 0));
                x = SEL_W'(v);
                tick();
                chk("rand_direct", 32'(y), 32'(fm(v)));
            end
            do_sweep(1'b0);
        end

        // start together with a leaf-0 write, then start held high.
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_code = 2'b11; mc[0] = 3;
        start = 1'b1;
        tick();
        cfg_we = 1'b0;
        tt_first = '0;
        for (int c = 0; c < 2 * (N + 1) + 2; c++) begin
            tick();
            if (sweep_valid) chk("b2b_y", 32'(y), 32'(fm(int'(sweep_x))));
            if (done) begin
                if (dq.size() == 0) tt_first = tt;
                dq.push_back(c);
            end
            if (dq.size() == 1 && c == dq[0] + 1)
                chk("b2b_gap_one", 32'(sweep_valid), 32'd1);
        end
        start = 1'b0;
        chk("b2b_done_count", 32'(dq.size()), 32'd2);
        chk("b2b_tt_lo", 32'(tt_first[1:0]), 32'b01);
        if (dq.size() >= 2) chk("b2b_spacing", 32'(dq[1] - dq[0]), 32'(N + 1));
        else chk("b2b_spacing_missing", 32'(dq.size()), 32'd2);
        for (int c = 0; c < N + 4; c++) tick();
        chk("b2b_idle_busy", 32'(busy), 32'd0);
        chk("b2b_tt_full", 32'(tt), 32'(ttm()));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lut_mux_seq.md
# lut_mux_seq

Parametrised, registered function generator built on the mux-with-residual-variable technique. The upper select bits choose a leaf; each leaf is programmed with a 2-bit code that resolves to 0, 1, the LSB variable, or its complement. The block adds a sequential sweep mode that steps through all select codes, streams out each result and captures the full truth table. It sits wherever a small reprogrammable logic function is needed, and serves as a self-test source for mux-based function cells.

## Interface
Parameters:
- SEL_W, 3, number of input variables; legal range 2 and up. Number of leaves NL = 2^(SEL_W-1), truth-table width N = 2^SEL_W.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- x  in  SEL_W  input variables for direct mode; x[SEL_W-1:1] is the leaf select, x[0] is the residual variable.
- cfg_we  in  1  leaf-code write enable.
- cfg_addr  in  SEL_W-1  leaf index to write.
- cfg_code  in  2  leaf code: 00=0, 01=1, 10=x[0], 11=~x[0].
- start  in  1  sweep request; level-sampled.
- y  out  1  registered function output.
- sweep_x  out  SEL_W  input code that produced the current y during a sweep.
- sweep_valid  out  1  y and sweep_x carry a sweep sample.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse when the sweep completes.
- tt  out  N  captured truth table; tt[k] = f(k).

## Operation
- Function: f(v) = decode(code[v[SEL_W-1:1]], v[0]), using the code meanings listed under cfg_code.
- Reset (rst_n=0 at an edge):
  - all leaf codes = 00, so f ≡ 0;
  - state = IDLE, counter = 0;
  - y = 0, sweep_x = 0, sweep_valid = 0, busy = 0, done = 0, tt = 0.
  - Reset overrides every other input, including mid-sweep.
- FSM states: IDLE, SWEEP, DONE.
- IDLE:
  - cfg_we=1 writes cfg_code into leaf cfg_addr.
  - y <= f(x) every edge.
  - start=1 -> go to SWEEP; counter <= 0, busy <= 1.
- SWEEP:
  - Each edge: y <= f(counter), sweep_x <= counter, sweep_valid <= 1, tt[counter] <= f(counter), counter <= counter+1.
  - The edge that evaluates counter = N-1 -> go to DONE.
  - cfg_we and start are ignored; x is ignored.
- DONE (one edge):
  - busy <= 0, sweep_valid <= 0, done <= 1, then go to IDLE.
  - y <= f(x) resumes on this edge.
  - tt is held until the next sweep overwrites it bit by bit.
- done is forced to 0 on every edge except the IDLE entry following DONE.
- Counter is SEL_W bits wide; the wrap from N-1 is never used because the FSM leaves SWEEP first.

## Timing
- Direct mode latency: 1 cycle from x/leaf-code change to y.
- A leaf write at edge E is visible in y at edge E+1 when x selects that leaf.
- Sweep timing, with start sampled at edge E0:
  - busy is high after E0.
  - sweep_valid is high for exactly N consecutive cycles, after E1 through E_N.
  - Sample k appears after E_(k+1).
  - After E_(N+1): busy=0, sweep_valid=0, done=1, tt complete.
  - After E_(N+2): done=0.
- Start-to-done: N+1 cycles.
- Simultaneous cfg_we and start in IDLE: the write completes at E0, and the sweep uses the updated code.
- start held high continuously: the next sweep begins at the edge after DONE (back-to-back), with a one-cycle gap in sweep_valid.
- Reset asserted mid-sweep: the next cycle shows the reset values; no done pulse.

## Test plan
- Reset check -> y, sweep_x, sweep_valid, busy, done all 0, tt=0. Drive x=0..7 in direct mode -> y=0 throughout.
- SEL_W=3, write leaf codes {0:01, 1:10, 2:11, 3:00}, drive x=0..7 (one per cycle) -> y sequence, one cycle late, = 1,1,0,1,1,0,0,0.
- Same codes, pulse start -> sweep_valid high for 8 cycles with sweep_x=0..7 and y=1,1,0,1,1,0,0,0; done high one cycle, 9 cycles after start; tt=8'h1B.
- During a sweep, cfg_we writes leaf 3 to 01 and start pulses again -> tt still 8'h1B, a single done pulse. A later sweep gives tt=8'hDB.
- rst_n=0 at sweep sample 4 -> the next cycle shows busy=0 and tt=0, with no done pulse; a new sweep gives tt=0.
- start and cfg_we (leaf 0 -> 11) in the same cycle, then hold start high -> the first sweep uses the new code (tt[1:0]=2'b01); two back-to-back sweeps occur, with done pulses separated by 9 cycles.
